spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master transfer controller sequencing one chip-select-framed shift transaction per start request. It sits between the APB register bank (write registers supply `tx_data`, `tx_len`, `start`; read registers capture `rx_data` and status) and the external SPI pins. It generates its own SPI clock from PCLK, so no separate divider is needed. Mode 0 only: CPOL=0, CPHA=0, MSB first.

## Interface
- `DWIDTH`, 32: maximum transfer length in bits and width of the data ports.
- `CLK_DIV`, 2: SPI_CLK half-period in PCLK cycles. Must be ≥1.
- `LWIDTH`, $clog2(DWIDTH)+1: width of `tx_len`.

- `PCLK` in 1: single clock. All logic rises on PCLK.
- `PRESETn` in 1: asynchronous, active-low reset.
- `start` in 1: transfer request. Level is sampled each cycle.
- `tx_len` in LWIDTH: bits to transfer. Legal range is 1..DWIDTH.
- `tx_data` in DWIDTH: transmit word. Bit `tx_len-1` is sent first.
- `rx_data` out DWIDTH: received word, LSB-aligned, upper bits zero. Reset value 0.
- `busy` out 1: transfer in progress. Reset value 0.
- `done` out 1: one-cycle completion pulse. Reset value 0.
- `err` out 1: one-cycle pulse when a start is rejected. Reset value 0.
- `SPI_CLK` out 1: serial clock. Idles at 0. Reset value 0.
- `SPI_CS_N` out 1: chip select, active low. Reset value 1.
- `SPI_MOSI` out 1: serial data out. Reset value 0.
- `SPI_MISO` in 1: serial data in.

## Operation
- States and transitions:
  - IDLE → SETUP → SHIFT_HI → SHIFT_LO → (SHIFT_HI | IDLE).
  - All outputs are registered.
- IDLE:
  - If `start`=1 and 1≤`tx_len`≤DWIDTH: latch `tx_data` into the tx shift register, left-justified at bit `tx_len-1`. Latch `tx_len` into the bit counter. Clear the rx shift register. Go to SETUP.
  - If `start`=1 and `tx_len`=0 or `tx_len`>DWIDTH: pulse `err` for one cycle and stay in IDLE. SPI pins do not move.
- SETUP:
  - `SPI_CS_N`=0, `SPI_CLK`=0, `SPI_MOSI`=first bit.
  - Lasts CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - `SPI_CLK`=1 for CLK_DIV cycles.
  - `SPI_MISO` is shifted into the rx register LSB at the PCLK edge ending the first SHIFT_HI cycle.
- SHIFT_LO:
  - `SPI_CLK`=0 for CLK_DIV cycles.
  - `SPI_MOSI` advances to the next bit on entry.
  - Bit counter decrements on entry.
  - When the counter reaches 0, SHIFT_LO acts as CS hold time: `SPI_MOSI` holds the last bit. Then go to IDLE.
- Return to IDLE:
  - `SPI_CS_N`=1 and `busy`=0.
  - `rx_data` is loaded from the rx shift register and `done`=1, in the same cycle.
  - `rx_data` then holds until the next completion or reset.
- `busy`=1 in all states except IDLE.
- `start` while `busy`=1 is ignored silently: no `err`, and the transfer is unaffected.
- Inputs are not re-sampled during a transfer. Changes to `tx_data` or `tx_len` after acceptance have no effect.
- `rx_data` bit mapping: the first received bit lands in bit `tx_len-1`, the last in bit 0.

## Timing
- Let E0 be the PCLK edge at which `start` is accepted.
- `SPI_CS_N` falls and `busy` rises after E0.
- First `SPI_CLK` rise is after E0+CLK_DIV.
- `SPI_CS_N` rises and `done` pulses after E0 + CLK_DIV + 2·CLK_DIV·`tx_len`.
- Example, CLK_DIV=2 and `tx_len`=8: 34 cycles.
- Back-to-back transfers: `start` held high through the `done` cycle is accepted at that edge. `SPI_CS_N` is then high for exactly one PCLK cycle between transfers.
- `err` appears one cycle after the rejected-start edge.
- `PRESETn` low at any time, including mid-transfer:
  - All outputs go to their reset values immediately (asynchronous).
  - State returns to IDLE and shift registers and counters clear.
  - No `done` is produced for the aborted transfer.
- Reset release: the first `start` can be accepted at the first PCLK edge with `PRESETn`=1.

## Structure
- Package `spi_pkg` holds:
  - the state typedef `spi_state_e` (IDLE, SETUP, SHIFT_HI, SHIFT_LO);
  - localparam helpers for LWIDTH and the half-period counter width $clog2(CLK_DIV+1).
- Sub-module `spi_half_timer`:
  - counts CLK_DIV PCLK cycles and pulses `tick` on the last cycle;
  - reloads on state change and is cleared by PRESETn.
- The top level holds the FSM, the tx/rx shift registers and the bit counter.

## Test plan
1. CLK_DIV=2, `tx_len`=8, `tx_data`=0xA5, MISO looped to MOSI → MOSI sequence 1,0,1,0,0,1,0,1; `rx_data`=0x000000A5; `done` exactly 34 cycles after acceptance; 8 SPI_CLK rising edges.
2. `tx_len`=32, `tx_data`=0xDEADBEEF, MISO tied 1 → `rx_data`=0xFFFFFFFF; `SPI_CS_N` low for 130 cycles.
3. `tx_len`=0, then `tx_len`=33 → one `err` pulse each; `SPI_CS_N` stays 1; `busy` stays 0; `rx_data` unchanged.
4. Second `start` pulse with `tx_data` changed to 0x00 mid-transfer → ignored; no `err`; first transfer completes with its original MOSI bits.
5. `PRESETn` asserted during the 3rd SHIFT_HI → same cycle `SPI_CS_N`=1, `SPI_CLK`=0, `busy`=0, `rx_data`=0; after release, a new 4-bit transfer of 0x9 completes normally.
6. `start` held high continuously, `tx_len`=4 → consecutive transfers with `SPI_CS_N` high exactly 1 cycle between them; `done` pulses every 2+16+1 = 19 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, default parameters and width helpers for the SPI master.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO} spi_state_e;
    localparam int DEF_DWIDTH  = 32;
    localparam int DEF_CLK_DIV = 2;
    function automatic int len_width(input int dwidth);
        return $clog2(dwidth) + 1;
    endfunction
    function automatic int half_width(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction
endpackage

// File: rtl/spi_half_timer.sv
// spi_half_timer: counts CLK_DIV PCLK cycles per FSM state, flagging the first and last cycle.
module spi_half_timer import spi_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic i_restart,
    output logic o_tick,
    output logic o_first
);
    localparam int CW = half_width(CLK_DIV);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_cnt <= '0;
        else          r_cnt <= (i_restart || o_tick) ? '0 : r_cnt + 1'b1;
    end
    assign o_tick  = r_cnt == CW'(CLK_DIV - 1);
    assign o_first = r_cnt == '0;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master running one CS-framed, MSB-first transfer per start.
// Outputs are registered from the next state so pins change in step with the FSM.
module spi_master_ctrl import spi_pkg::*; #(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int LWIDTH  = len_width(DWIDTH)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              start,
    input  logic [LWIDTH-1:0] tx_len,
    input  logic [DWIDTH-1:0] tx_data,
    output logic [DWIDTH-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              SPI_CLK,
    output logic              SPI_CS_N,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO
);
    spi_state_e        r_state, w_next;
    logic [DWIDTH-2:0] r_tx;
    logic [DWIDTH-1:0] r_rx, w_tx_just;
    logic [LWIDTH-1:0] r_bits, w_shamt;
    logic              w_tick, w_first, w_valid, w_accept;

    spi_half_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_restart (w_next != r_state),
        .o_tick    (w_tick),
        .o_first   (w_first)
    );

    always_comb begin
        w_valid   = (tx_len != '0) && (tx_len <= LWIDTH'(DWIDTH));
        w_shamt   = LWIDTH'(DWIDTH) - tx_len;
        w_tx_just = tx_data << w_shamt;
        w_accept  = (r_state == IDLE) && start && w_valid;
        w_next    = r_state;
        case (r_state)
            IDLE:     w_next = w_accept ? SETUP : IDLE;
            SETUP:    w_next = w_tick ? SHIFT_HI : SETUP;
            SHIFT_HI: w_next = w_tick ? SHIFT_LO : SHIFT_HI;
            SHIFT_LO: w_next = w_tick ? ((r_bits == '0) ? IDLE : SHIFT_HI) : SHIFT_LO;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx     <= '0;
            r_rx     <= '0;
            r_bits   <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            SPI_CLK  <= 1'b0;
            SPI_CS_N <= 1'b1;
            SPI_MOSI <= 1'b0;
        end else begin
            SPI_CLK  <= w_next == SHIFT_HI;
            SPI_CS_N <= w_next == IDLE;
            busy     <= w_next != IDLE;
            done     <= (r_state == SHIFT_LO) && (w_next == IDLE);
            err      <= (r_state == IDLE) && start && !w_valid;
            if (w_accept) begin
                r_tx     <= w_tx_just[DWIDTH-2:0];
                SPI_MOSI <= w_tx_just[DWIDTH-1];
                r_bits   <= tx_len;
                r_rx     <= '0;
            end
            if ((r_state == SHIFT_HI) && w_first) r_rx <= {r_rx[DWIDTH-2:0], SPI_MISO};
            // On the final bit MOSI is left alone so it stays valid through CS hold.
            if ((r_state == SHIFT_HI) && (w_next == SHIFT_LO)) begin
                r_bits <= r_bits - 1'b1;
                r_tx   <= r_tx << 1;
                if (r_bits != LWIDTH'(1)) SPI_MOSI <= r_tx[DWIDTH-2];
            end
            if ((r_state == SHIFT_LO) && (w_next == IDLE)) rx_data <= r_rx;
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed checks of the SPI master with DWIDTH=32, CLK_DIV=2.
module tb_spi_master_ctrl;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  tx_len = '0;
    logic [31:0] tx_data = '0;
    logic [31:0] rx_data;
    logic        busy, done, err, SPI_CLK, SPI_CS_N, SPI_MOSI, SPI_MISO;
    logic        loop = 1'b1;
    logic        miso_val = 1'b0;
    int          total = 0;
    int          bad = 0;

    assign SPI_MISO = loop ? SPI_MOSI : miso_val;
    always #5 PCLK = ~PCLK;

    spi_master_ctrl dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .tx_len(tx_len), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .err(err), .SPI_CLK(SPI_CLK),
        .SPI_CS_N(SPI_CS_N), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
    );

    // Accepts a transfer, then samples every negedge (n=0 right after the accept edge) until done.
    task automatic xfer(input logic [5:0] len, input logic [31:0] data, input int inj,
                        output int done_at, output int rises, output logic [31:0] mbits,
                        output int cs_low, output int errs);
        logic prev;
        @(negedge PCLK);
        PRESETn = 1'b1; tx_len = len; tx_data = data; start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        done_at = -1; rises = 0; mbits = '0; cs_low = 0; errs = 0; prev = 1'b0;
        for (int n = 0; n < 400 && done_at < 0; n++) begin
            if (n > 0) @(negedge PCLK);
            if (n == inj) begin start = 1'b1; tx_data = '0; tx_len = 6'd33; end
            if (n == inj + 1) begin start = 1'b0; tx_data = data; tx_len = len; end
            if (SPI_CLK && !prev) begin rises++; mbits = {mbits[30:0], SPI_MOSI}; end
            prev = SPI_CLK;
            if (!SPI_CS_N) cs_low++;
            if (err) errs++;
            if (done) done_at = n;
        end
    endtask

    task automatic test_reset;
        tx_len = 6'd8; tx_data = 32'hFF; start = 1'b1;
        repeat (3) @(negedge PCLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        total++; if (SPI_CLK !== 1'b0) begin bad++; $display("FAIL rst_clk got=%b want=0", SPI_CLK); end
        total++; if (SPI_CS_N !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b want=1", SPI_CS_N); end
        total++; if (SPI_MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b want=0", SPI_MOSI); end
        total++; if (rx_data !== 32'h0) begin bad++; $display("FAIL rst_rx got=%h want=0", rx_data); end
        start = 1'b0;
    endtask

    task automatic test_basic;
        int d, r, c, e;
        logic [31:0] m;
        loop = 1'b1;
        xfer(6'd8, 32'hA5, -1, d, r, m, c, e);
        total++; if (d !== 34) begin bad++; $display("FAIL t1_done_at got=%0d want=34", d); end
        total++; if (r !== 8) begin bad++; $display("FAIL t1_rises got=%0d want=8", r); end
        total++; if (m !== 32'hA5) begin bad++; $display("FAIL t1_mosi got=%h want=a5", m); end
        total++; if (rx_data !== 32'hA5) begin bad++; $display("FAIL t1_rx got=%h want=a5", rx_data); end
        total++; if (c !== 34) begin bad++; $display("FAIL t1_cs_low got=%0d want=34", c); end
        @(negedge PCLK);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_width got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_full_len;
        int d, r, c, e;
        logic [31:0] m;
        loop = 1'b0; miso_val = 1'b1;
        xfer(6'd32, 32'hDEADBEEF, -1, d, r, m, c, e);
        total++; if (d !== 130) begin bad++; $display("FAIL t2_done_at got=%0d want=130", d); end
        total++; if (c !== 130) begin bad++; $display("FAIL t2_cs_low got=%0d want=130", c); end
        total++; if (r !== 32) begin bad++; $display("FAIL t2_rises got=%0d want=32", r); end
        total++; if (m !== 32'hDEADBEEF) begin bad++; $display("FAIL t2_mosi got=%h want=deadbeef", m); end
        total++; if (rx_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL t2_rx got=%h want=ffffffff", rx_data); end
        loop = 1'b1;
    endtask

    task automatic test_bad_len;
        logic [5:0] lens [2];
        lens[0] = 6'd0; lens[1] = 6'd33;
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            tx_len = lens[i]; start = 1'b1;
            @(negedge PCLK);
            start = 1'b0;
            total++; if (err !== 1'b1) begin bad++; $display("FAIL t3_err len=%0d got=%b want=1", lens[i], err); end
            total++; if (SPI_CS_N !== 1'b1) begin bad++; $display("FAIL t3_cs len=%0d got=%b want=1", lens[i], SPI_CS_N); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_busy len=%0d got=%b want=0", lens[i], busy); end
            @(negedge PCLK);
            total++; if (err !== 1'b0) begin bad++; $display("FAIL t3_err_width len=%0d got=%b want=0", lens[i], err); end
        end
        total++; if (rx_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL t3_rx got=%h want=ffffffff", rx_data); end
    endtask

    task automatic test_busy_start;
        int d, r, c, e;
        logic [31:0] m;
        xfer(6'd8, 32'hC3, 10, d, r, m, c, e);
        total++; if (e !== 0) begin bad++; $display("FAIL t4_err got=%0d want=0", e); end
        total++; if (m !== 32'hC3) begin bad++; $display("FAIL t4_mosi got=%h want=c3", m); end
        total++; if (rx_data !== 32'hC3) begin bad++; $display("FAIL t4_rx got=%h want=c3", rx_data); end
        total++; if (d !== 34) begin bad++; $display("FAIL t4_done_at got=%0d want=34", d); end
    endtask

    task automatic test_abort;
        int d, r, c, e, rises;
        logic [31:0] m;
        logic prev;
        @(negedge PCLK);
        tx_len = 6'd8; tx_data = 32'hFF; start = 1'b1;
        @(negedge PCLK);
        start = 1'b0; rises = 0; prev = 1'b0;
        for (int n = 0; n < 100 && rises < 3; n++) begin
            if (n > 0) @(negedge PCLK);
            if (SPI_CLK && !prev) rises++;
            prev = SPI_CLK;
        end
        total++; if (rises !== 3) begin bad++; $display("FAIL t5_reach_hi got=%0d want=3", rises); end
        #1 PRESETn = 1'b0;
        #1;
        total++; if (SPI_CS_N !== 1'b1) begin bad++; $display("FAIL t5_cs got=%b want=1", SPI_CS_N); end
        total++; if (SPI_CLK !== 1'b0) begin bad++; $display("FAIL t5_clk got=%b want=0", SPI_CLK); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy got=%b want=0", busy); end
        total++; if (rx_data !== 32'h0) begin bad++; $display("FAIL t5_rx got=%h want=0", rx_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t5_done got=%b want=0", done); end
        xfer(6'd4, 32'h9, -1, d, r, m, c, e);
        total++; if (d !== 18) begin bad++; $display("FAIL t5_done_at got=%0d want=18", d); end
        total++; if (m !== 32'h9) begin bad++; $display("FAIL t5_mosi got=%h want=9", m); end
        total++; if (rx_data !== 32'h9) begin bad++; $display("FAIL t5_rx_new got=%h want=9", rx_data); end
    endtask

    task automatic test_back_to_back;
        int dts [3];
        int nd, cs_hi, errs;
        nd = 0; cs_hi = 0; errs = 0;
        dts[0] = -1; dts[1] = -1; dts[2] = -1;
        @(negedge PCLK);
        tx_len = 6'd4; tx_data = 32'h6; start = 1'b1;
        for (int n = 0; n < 200 && nd < 3; n++) begin
            @(negedge PCLK);
            if (nd >= 1 && SPI_CS_N) cs_hi++;
            if (err) errs++;
            if (done) begin dts[nd] = n; nd++; end
        end
        start = 1'b0;
        total++; if (dts[0] !== 18) begin bad++; $display("FAIL t6_first_done got=%0d want=18", dts[0]); end
        total++; if (dts[1] - dts[0] !== 19) begin bad++; $display("FAIL t6_period1 got=%0d want=19", dts[1] - dts[0]); end
        total++; if (dts[2] - dts[1] !== 19) begin bad++; $display("FAIL t6_period2 got=%0d want=19", dts[2] - dts[1]); end
        total++; if (cs_hi !== 2) begin bad++; $display("FAIL t6_cs_gap got=%0d want=2", cs_hi); end
        total++; if (errs !== 0) begin bad++; $display("FAIL t6_err got=%0d want=0", errs); end
        total++; if (rx_data !== 32'h6) begin bad++; $display("FAIL t6_rx got=%h want=6", rx_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_len();
        test_bad_len();
        test_busy_start();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
